// File: rtl/pipe_fetch_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipe_fetch_pkg
// Purpose  : Shared constants, FSM encoding and helpers for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_fetch_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_FULL  = 1'b1
  } fetch_state_t;

  // Fetch addresses are always word aligned; low address bits are discarded.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_fetch_skid.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipe_fetch_skid
// Purpose  : One-entry {instr, pcplus4} holding register absorbing a fetch
//            response that arrives while ID is stalled.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_fetch_skid
  import pipe_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pcplus4,
  input  logic        drain,
  input  logic        clear,
  output logic        full,
  output logic [31:0] instr,
  output logic [31:0] pcplus4
);

  logic        r_full;
  logic [31:0] r_instr;
  logic [31:0] r_pcplus4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full    <= 1'b0;
      r_instr   <= NOP_INSTR;
      r_pcplus4 <= 32'h0;
    end else begin
      if (clear || drain) begin
        r_full <= 1'b0;
      end else if (load) begin
        r_full <= 1'b1;
      end
      if (load) begin
        r_instr   <= load_instr;
        r_pcplus4 <= load_pcplus4;
      end
    end
  end

  assign full    = r_full;
  assign instr   = r_instr;
  assign pcplus4 = r_pcplus4;

endmodule
`default_nettype wire

// File: rtl/pipe_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipe_fetch
// Purpose  : Instruction-fetch stage: owns the fetch PC, reads instruction
//            memory over req/ack and feeds the IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_fetch
  import pipe_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pcplus4
);

  localparam logic [31:0] c_PC_STEP = 32'(WORD_BYTES);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic         r_started;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  w_fetch_pc_nxt;
  logic         r_kill;
  logic         w_kill_nxt;
  logic [31:0]  r_target_q;
  logic [31:0]  w_target_nxt;
  logic         r_if_valid;
  logic         w_if_valid_nxt;
  logic [31:0]  r_if_instr;
  logic [31:0]  w_if_instr_nxt;
  logic [31:0]  r_if_pcplus4;
  logic [31:0]  w_if_pcplus4_nxt;

  logic         w_skid_load;
  logic         w_skid_drain;
  logic         w_skid_clear;
  logic         w_skid_full;
  logic [31:0]  w_skid_instr;
  logic [31:0]  w_skid_pcplus4;

  logic         w_accept;
  logic         w_ack;
  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_redirect_pc;

  // Request is held low until the first edge after reset release.
  assign imem_req      = r_started && (r_state == ST_FETCH);
  assign imem_addr     = r_fetch_pc;
  assign w_ack         = imem_req && imem_ack;
  assign w_accept      = !r_if_valid || !stall;
  assign w_pc_plus4    = r_fetch_pc + c_PC_STEP;
  assign w_redirect_pc = word_align(redirect_pc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_FETCH;
      r_started    <= 1'b0;
      r_fetch_pc   <= word_align(RESET_PC);
      r_kill       <= 1'b0;
      r_target_q   <= 32'h0;
      r_if_valid   <= 1'b0;
      r_if_instr   <= NOP_INSTR;
      r_if_pcplus4 <= 32'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_started    <= 1'b1;
      r_fetch_pc   <= w_fetch_pc_nxt;
      r_kill       <= w_kill_nxt;
      r_target_q   <= w_target_nxt;
      r_if_valid   <= w_if_valid_nxt;
      r_if_instr   <= w_if_instr_nxt;
      r_if_pcplus4 <= w_if_pcplus4_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_fetch_pc_nxt   = r_fetch_pc;
    w_kill_nxt       = r_kill;
    w_target_nxt     = r_target_q;
    w_if_valid_nxt   = r_if_valid;
    w_if_instr_nxt   = r_if_instr;
    w_if_pcplus4_nxt = r_if_pcplus4;
    w_skid_load      = 1'b0;
    w_skid_drain     = 1'b0;
    w_skid_clear     = 1'b0;

    if (redirect) begin
      w_if_valid_nxt = 1'b0;
      w_if_instr_nxt = NOP_INSTR;
      w_skid_clear   = 1'b1;
      if (r_state == ST_FULL) begin
        w_fetch_pc_nxt = w_redirect_pc;
        w_state_nxt    = ST_FETCH;
      end else if (w_ack || !imem_req) begin
        w_fetch_pc_nxt = w_redirect_pc;
        w_kill_nxt     = 1'b0;
      end else begin
        // Address must stay put until the in-flight read completes.
        w_kill_nxt   = 1'b1;
        w_target_nxt = w_redirect_pc;
      end
    end else if (r_state == ST_FETCH) begin
      if (w_ack && r_kill) begin
        w_fetch_pc_nxt = r_target_q;
        w_kill_nxt     = 1'b0;
        if (w_accept) begin
          w_if_valid_nxt = 1'b0;
        end
      end else if (w_ack) begin
        w_fetch_pc_nxt = w_pc_plus4;
        if (w_accept) begin
          w_if_valid_nxt   = 1'b1;
          w_if_instr_nxt   = imem_rdata;
          w_if_pcplus4_nxt = w_pc_plus4;
        end else begin
          w_skid_load = 1'b1;
          w_state_nxt = ST_FULL;
        end
      end else if (w_accept) begin
        w_if_valid_nxt = 1'b0;
      end
    end else begin
      if (!stall && w_skid_full) begin
        w_if_valid_nxt   = 1'b1;
        w_if_instr_nxt   = w_skid_instr;
        w_if_pcplus4_nxt = w_skid_pcplus4;
        w_skid_drain     = 1'b1;
        w_state_nxt      = ST_FETCH;
      end
    end
  end

  pipe_fetch_skid u_skid (
    .clk          (clk),
    .reset        (reset),
    .load         (w_skid_load),
    .load_instr   (imem_rdata),
    .load_pcplus4 (w_pc_plus4),
    .drain        (w_skid_drain),
    .clear        (w_skid_clear),
    .full         (w_skid_full),
    .instr        (w_skid_instr),
    .pcplus4      (w_skid_pcplus4)
  );

  assign if_valid   = r_if_valid;
  assign if_instr   = r_if_instr;
  assign if_pcplus4 = r_if_pcplus4;

endmodule
`default_nettype wire

// File: tb/tb_pipe_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pipe_fetch
// Purpose  : Scoreboard bench for pipe_fetch with a latency-programmable
//            instruction memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_fetch;

  localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

  logic        clk         = 1'b0;
  logic        reset       = 1'b0;
  logic        stall       = 1'b0;
  logic        redirect    = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack    = 1'b0;
  logic [31:0] imem_rdata  = 32'h0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pcplus4;

  int checks = 0;
  int errors = 0;

  // Memory model controls: acks allowed while done < budget.
  int          lat       = 0;
  int          budget    = 0;
  int          done      = 0;
  int          cnt       = 0;
  logic [31:0] hold_addr = 32'h0;
  logic [31:0] mem_e;
  logic [63:0] mon_e;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_out_q[$];

  pipe_fetch #(.RESET_PC(c_RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pcplus4  (if_pcplus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic grant(input int n);
    budget = done + n;
  endtask

  task automatic push_out(input logic [31:0] a);
    exp_out_q.push_back({mem_word(a), a + 32'd4});
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((exp_out_q.size() != 0 || exp_addr_q.size() != 0) && k < 200) begin
      tick();
      k++;
    end
    checks++;
    if (k >= 200) begin
      errors++;
      $display("FAIL %s_drain: got %0d outputs / %0d reads pending, required 0",
               name, exp_out_q.size(), exp_addr_q.size());
      exp_out_q.delete();
      exp_addr_q.delete();
    end
    tick();
  endtask

  // Memory responder: checks request address order and stability.
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      imem_ack = 1'b0;
      cnt      = 0;
    end else if (imem_req && done < budget) begin
      if (cnt > 0) chk("addr_stable", imem_addr, hold_addr);
      if (cnt == lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        done++;
        cnt = 0;
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got %h required none", imem_addr);
        end else begin
          mem_e = exp_addr_q.pop_front();
          chk("req_addr", imem_addr, mem_e);
        end
      end else begin
        imem_ack = 1'b0;
        if (cnt == 0) hold_addr = imem_addr;
        cnt++;
      end
    end else begin
      imem_ack = 1'b0;
    end
  end

  // Output monitor: an instruction is consumed on a non-stalled, non-flushed cycle.
  always @(negedge clk) begin
    if (reset && if_valid && !stall && !redirect) begin
      if (exp_out_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got instr %h pcplus4 %h required none", if_instr, if_pcplus4);
      end else begin
        mon_e = exp_out_q.pop_front();
        chk("out_instr", if_instr, mon_e[63:32]);
        chk("out_pcplus4", if_pcplus4, mon_e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    chk1("rst_valid", if_valid, 1'b0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pcplus4", if_pcplus4, 32'h0);
    chk1("rst_req", imem_req, 1'b0);

    // Zero-wait streaming from RESET_PC
    lat = 0;
    grant(4);
    for (int i = 0; i < 4; i++) begin
      exp_addr_q.push_back(32'h0 + 32'(4 * i));
      push_out(32'h0 + 32'(4 * i));
    end
    reset = 1'b1;
    #1;
    chk1("release_req", imem_req, 1'b0);
    tick();
    chk1("edge1_req", imem_req, 1'b1);
    chk("edge1_addr", imem_addr, c_RESET_PC);
    chk1("edge1_valid", if_valid, 1'b0);
    tick();
    chk1("edge2_valid", if_valid, 1'b1);
    chk("edge2_pcplus4", if_pcplus4, 32'h4);
    wait_drain("stream");

    // Stall for three cycles: skid fills, request drops
    grant(4);
    for (int i = 0; i < 4; i++) begin
      exp_addr_q.push_back(32'h10 + 32'(4 * i));
      push_out(32'h10 + 32'(4 * i));
    end
    tick();
    stall = 1'b1;
    chk1("stall_valid", if_valid, 1'b1);
    chk("stall_instr", if_instr, mem_word(32'h10));
    tick();
    chk1("full_req_a", imem_req, 1'b0);
    tick();
    chk1("full_req_b", imem_req, 1'b0);
    chk("stall_hold_instr", if_instr, mem_word(32'h10));
    tick();
    stall = 1'b0;
    wait_drain("stall");

    // Slow memory, two redirects while 0x20 is in flight (latest wins)
    lat = 3;
    grant(2);
    exp_addr_q.push_back(32'h20);
    exp_addr_q.push_back(32'h100);
    push_out(32'h100);
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0F0;
    tick();
    redirect_pc = 32'h100;
    chk("kill_addr_a", imem_addr, 32'h20);
    tick();
    redirect = 1'b0;
    chk("kill_addr_b", imem_addr, 32'h20);
    chk1("kill_valid", if_valid, 1'b0);
    tick();
    chk1("kill_drop_valid", if_valid, 1'b0);
    chk("kill_next_addr", imem_addr, 32'h100);
    wait_drain("kill");
    lat = 0;

    // Redirect coincident with ack while stalled
    grant(2);
    exp_addr_q.push_back(32'h104);
    exp_addr_q.push_back(32'h108);
    tick();
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    chk1("redir_ack_valid", if_valid, 1'b0);
    chk("redir_ack_instr", if_instr, 32'h0);
    chk("redir_ack_addr", imem_addr, 32'h200);
    chk1("redir_ack_req", imem_req, 1'b1);
    grant(1);
    exp_addr_q.push_back(32'h200);
    push_out(32'h200);
    tick();
    chk1("empty_stall_valid", if_valid, 1'b1);
    chk("empty_stall_pcplus4", if_pcplus4, 32'h204);
    repeat (2) tick();
    stall = 1'b0;
    wait_drain("redir_ack");

    // Asynchronous reset while a slow read is outstanding
    stall = 1'b1;
    grant(1);
    exp_addr_q.push_back(32'h204);
    tick();
    chk1("pre_reset_valid", if_valid, 1'b1);
    lat = 3;
    grant(1);
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk1("async_valid", if_valid, 1'b0);
    chk("async_instr", if_instr, 32'h0);
    chk("async_pcplus4", if_pcplus4, 32'h0);
    chk1("async_req", imem_req, 1'b0);
    budget = done;
    tick();
    chk1("async_hold_req", imem_req, 1'b0);
    reset = 1'b1;
    stall = 1'b0;
    lat   = 0;
    grant(1);
    exp_addr_q.push_back(c_RESET_PC);
    push_out(c_RESET_PC);
    tick();
    chk1("post_reset_req", imem_req, 1'b1);
    chk("post_reset_addr", imem_addr, c_RESET_PC);
    wait_drain("async");

    // Alignment: redirect to 0x103 fetches 0x100
    grant(2);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h100);
    push_out(32'h100);
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    tick();
    redirect = 1'b0;
    chk("align_addr", imem_addr, 32'h100);
    wait_drain("align");

    // Wrap: redirect to 0xFFFF_FFFC, pcplus4 and next fetch wrap to 0
    grant(2);
    exp_addr_q.push_back(32'h104);
    exp_addr_q.push_back(32'hFFFF_FFFC);
    push_out(32'hFFFF_FFFC);
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk1("wrap_valid", if_valid, 1'b1);
    chk("wrap_pcplus4", if_pcplus4, 32'h0);
    chk("wrap_next_addr", imem_addr, 32'h0);
    wait_drain("wrap");
    grant(1);
    exp_addr_q.push_back(32'h0);
    push_out(32'h0);
    wait_drain("wrap_resume");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_fetch.md
Name: pipe_fetch

Overview:
- Instruction-fetch stage: owns the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Delivers fetched instructions to the IF/ID pipeline register on if_instr/if_pcplus4 with a valid flag.
- Honours ID-stage stall (backpressure) and branch/jump redirect (flush).
- Sits between instruction memory and pipe_if2id; it is the producer end of the IF→ID interface.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset (word aligned).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  ID cannot accept; hold current output.
- redirect  in  1  one-cycle pulse: flush and refetch from redirect_pc.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 00).
- imem_req  out  1  read request, level.
- imem_addr  out  32  read address; stable while imem_req=1 and not acked.
- imem_ack  in  1  one-cycle pulse, imem_rdata valid; may arrive in the same cycle as req (zero-wait).
- imem_rdata  in  32  instruction word.
- if_valid  out  1  if_instr/if_pcplus4 hold a live instruction.
- if_instr  out  32  instruction to IF/ID.
- if_pcplus4  out  32  address of if_instr plus 4.

Behaviour:
- Reset (async, reset=0):
  - fetch_pc=RESET_PC; state FETCH; kill=0; skid empty.
  - if_valid=0, if_instr=NOP (32'h0), if_pcplus4=0.
  - imem_req=0 while reset is low; imem_req=1 from the first clock edge after release.
- Output slot accepts new data when (!if_valid || !stall).
- State FETCH: imem_req=1, imem_addr=fetch_pc.
  - On ack, kill=0, no redirect:
    - fetch_pc<=fetch_pc+4 (mod 2^32).
    - If slot accepts: output<=rdata, pcplus4<=fetch_pc+4, if_valid<=1.
    - Else: skid<=(rdata, fetch_pc+4); go FULL.
  - No ack and slot accepts: if_valid<=0 (bubble; if_instr keeps its last value).
- State FULL: imem_req=0.
  - When !stall: output<=skid, if_valid<=1, skid empty, go FETCH.
  - No bubble between skid drain and the next fetch.
- Throughput: 1 instruction/cycle with zero-wait memory and no stall. Latency: ack edge → if_valid next edge.
- Redirect has priority over stall and ack. On the redirect edge:
  - if_valid<=0, if_instr<=NOP, skid emptied.
  - In FULL: fetch_pc<=redirect_pc; go FETCH.
  - In FETCH with ack the same cycle: returned data dropped; fetch_pc<=redirect_pc.
  - In FETCH without ack (request in flight): imem_addr held unchanged (protocol); kill<=1; target_q<=redirect_pc.
- Kill handling:
  - While kill=1, a further redirect overwrites target_q (latest wins).
  - On ack with kill=1: data dropped, fetch_pc<=target_q, kill<=0.
- Stall with if_valid=0: slot still accepts; stall is ignored for empty output.
- Async reset mid-request: all state cleared immediately; the outstanding memory response is not tracked. The memory side is reset by the same signal.
- Invariants: skid is never occupied in FETCH; at most one memory request is outstanding.

Decomposition:
- Shared header (alongside simparams.vh): NOP_INSTR=32'h0, state encodings FETCH/FULL, WORD_BYTES=4.
- One sub-module: fetch_skid, a one-entry {instr, pcplus4} holding register with load/drain/clear and full flag.
- FSM, PC and kill logic stay in pipe_fetch.

Test Plan:
- Reset release, memory acks in the same cycle as req → imem_addr 0x0,0x4,0x8,…; if_valid=1 from the 2nd edge; if_pcplus4 0x4,0x8,0xC.
- stall=1 for 3 cycles with if_valid=1 →
  - Output frozen; next word goes to skid; imem_req=0 during FULL.
  - On release: skid word appears next cycle, then fetch resumes with no gap or duplicate.
- 3-cycle memory, redirect to 0x100 one cycle after req to 0x20 →
  - imem_addr stays 0x20 until ack; 0x20 data dropped; if_valid=0.
  - Next imem_addr=0x100; if_pcplus4=0x104.
- Redirect coincident with ack and stall=1 → data dropped, if_valid=0, skid empty, next imem_addr=redirect_pc.
- Async reset asserted mid-wait → if_valid=0, if_instr=0, if_pcplus4=0, imem_req=0 immediately; after release imem_addr=RESET_PC.
- Wrap and alignment:
  - Redirect to 0x103 → imem_addr=0x100.
  - Redirect to 0xFFFF_FFFC → if_pcplus4=0x0, next imem_addr=0x0.
